wake_decide: RTL and testbench
==============================

WAKE_DECIDE -- requirements
Module: wake_decide

Interface
REQ-001 The block SHALL have parameter I_BW, default 24, meaning the signed per-class score bitwidth, equal to the upstream O_BW.
REQ-002 The block SHALL have parameter NUM_CLASSES, default 3, meaning the number of class scores per frame; legal values are 2 or more.
REQ-003 The block SHALL have parameter WAKE_CLASS, default 1, meaning the class index that counts as a wake detection.
REQ-004 The block SHALL have parameter THRESH, default 100, meaning the signed minimum winning score for a detection.
REQ-005 The block SHALL have parameter WAKE_COUNT, default 2, meaning the number of consecutive detecting frames required to fire wake.
REQ-006 The block SHALL have port clk_i, input, width 1, meaning the single clock.
REQ-007 The block SHALL have port rst_n_i, input, width 1, meaning reset; reset is asynchronous and active-low.
REQ-008 The block SHALL have port data_i, input, NUM_CLASSES*I_BW bits, meaning the packed signed scores, class i in bits [(i+1)*I_BW-1 : i*I_BW].
REQ-009 The block SHALL have ports valid_i and last_i, input, width 1 each, meaning the upstream frame handshake.
REQ-010 The block SHALL have port ready_o, output, width 1, meaning the block can accept a frame.
REQ-011 The block SHALL have port class_o, output, $clog2(NUM_CLASSES) bits, meaning the winning class index.
REQ-012 The block SHALL have port score_o, output, I_BW bits, meaning the winning signed score.
REQ-013 The block SHALL have port wake_o, output, width 1, meaning the wake decision for the presented frame.
REQ-014 The block SHALL have ports valid_o and last_o, output, width 1 each, meaning the downstream handshake.
REQ-015 The block SHALL have port ready_i, input, width 1, meaning downstream can accept.

Function
REQ-016 The FSM SHALL have states IDLE, SCAN and OUT.
REQ-017 ready_o SHALL be 1 only in IDLE.
REQ-018 A frame SHALL be accepted on a rising edge where valid_i and ready_o are both 1.
- On acceptance, all scores and last_i are registered.
- best_idx is set to 0, best_score to score 0, scan index to 1, and state goes to SCAN.
REQ-019 Each SCAN cycle SHALL compare the score at the scan index against best_score, signed and strictly greater; on a win, best_idx and best_score update.
- The scan index then increments.
- After comparing index NUM_CLASSES-1, state goes to OUT.
REQ-020 Ties SHALL resolve to the lowest class index.
REQ-021 valid_o SHALL assert exactly NUM_CLASSES-1 rising edges after the accepting edge; for NUM_CLASSES=3 that is 2 edges.
REQ-022 class_o, score_o, wake_o and last_o SHALL be registered and SHALL hold stable while valid_o=1 and ready_i=0.
REQ-023 In OUT, a rising edge with ready_i=1 SHALL deassert valid_o and return the FSM to IDLE.
- The next frame can be accepted on the following edge, at the earliest.
REQ-024 valid_i seen while ready_o=0 SHALL be ignored (not queued).
- Upstream frames are single-beat, with valid and last together.
REQ-025 A detection SHALL be defined as best_idx==WAKE_CLASS and best_score>=THRESH (signed).
- It is evaluated on the SCAN-to-OUT transition.
REQ-026 The detect counter SHALL be $clog2(WAKE_COUNT+1) bits wide and SHALL update once per frame on the SCAN-to-OUT transition:
- on a detection, it increments;
- on a non-detection, it clears to 0;
- when an increment reaches WAKE_COUNT, wake_o=1 for that frame and the counter clears to 0.
REQ-027 wake_o SHALL be 0 whenever valid_o=0.
REQ-028 last_o SHALL equal the last_i captured with the frame.

Reset
REQ-029 While rst_n_i=0, the block SHALL immediately set:
- state to IDLE, ready_o to 0 during reset, then 1 in IDLE;
- valid_o, last_o, wake_o, class_o, score_o and the detect counter to 0.
REQ-030 A reset asserted mid-SCAN or mid-OUT SHALL discard the frame in progress and clear the detect history; no output SHALL appear for that frame.

Structure
REQ-031 The FSM state encodings and the class-index width constant SHALL live in the shared wrd package.
REQ-032 The detect counter (REQ-026) SHALL be a separate sub-module named wake_counter, with ports: frame strobe, detect, and fire.
- All other logic is inline in wake_decide.

Verification
(Parameters for all scenarios: I_BW=24, NUM_CLASSES=3, WAKE_CLASS=1, THRESH=100, WAKE_COUNT=2.)
REQ-033 Scores {c0=5, c1=-20, c2=7} with ready_i=1 -> class_o=2, score_o=7, valid_o rises 2 edges after acceptance for exactly 1 cycle, wake_o=0.
REQ-034 Scores {-50, -50, -60} -> class_o=0, score_o=-50 (tie on the signed negative maximum resolves to the lowest index).
REQ-035 Two consecutive frames of {0, 150, 10} -> wake_o=0 on frame 1 and wake_o=1 on frame 2; a third identical frame -> wake_o=0 (counter restarted).
REQ-036 Frames {0,150,0}, {0,99,0}, {0,150,0} -> wake_o=0 on all three (a sub-threshold frame clears the count).
REQ-037 ready_i=0 for 5 cycles after valid_o rises -> outputs stay stable, ready_o=0, and a valid_i pulse in that window is dropped; ready_i=1 -> IDLE, and the next frame is accepted one edge later.
REQ-038 Assert rst_n_i asynchronously between edges while in SCAN, after one prior detecting frame -> all outputs go to 0 at once; after release, frame {0,150,0} -> wake_o=0.

Source files
------------

// File: rtl/wrd_pkg.sv
// ============================================================================
// Module : wrd_pkg
// Brief  : Shared FSM state encodings and class-index width helper for wake_decide.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wrd_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_SCAN = 2'd1;
  localparam state_t S_OUT  = 2'd2;

  // Width of a class index; never narrower than one bit.
  function automatic int cls_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wake_counter.sv
// ============================================================================
// Module : wake_counter
// Brief  : Consecutive-detection counter; fires when WAKE_COUNT detections in a row.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wake_counter #(
  parameter int WAKE_COUNT = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic frame_i,
  input  logic detect_i,
  output logic fire_o
);

  localparam int CW = $clog2(WAKE_COUNT + 1);
  localparam logic [CW-1:0] c_TARGET = CW'(WAKE_COUNT);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_inc;

  assign w_inc  = r_cnt + CW'(1);
  assign fire_o = frame_i & detect_i & (w_inc == c_TARGET);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (frame_i) begin
      if (!detect_i || fire_o) r_cnt <= '0;
      else                     r_cnt <= w_inc;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wake_decide.sv
// ============================================================================
// Module : wake_decide
// Brief  : Per-frame argmax over class scores with debounced wake decision.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wake_decide
  import wrd_pkg::*;
#(
  parameter int I_BW        = 24,
  parameter int NUM_CLASSES = 3,
  parameter int WAKE_CLASS  = 1,
  parameter int THRESH      = 100,
  parameter int WAKE_COUNT  = 2,
  localparam int CLS_W      = cls_w(NUM_CLASSES)
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [NUM_CLASSES*I_BW-1:0] data_i,
  input  logic                        valid_i,
  input  logic                        last_i,
  output logic                        ready_o,
  output logic [CLS_W-1:0]            class_o,
  output logic [I_BW-1:0]             score_o,
  output logic                        wake_o,
  output logic                        valid_o,
  output logic                        last_o,
  input  logic                        ready_i
);

  localparam logic [CLS_W-1:0]       c_LAST_IDX = CLS_W'(NUM_CLASSES - 1);
  localparam logic [CLS_W-1:0]       c_WAKE_IDX = CLS_W'(WAKE_CLASS);
  localparam logic signed [I_BW-1:0] c_THRESH   = I_BW'(THRESH);

  state_t                  r_state;
  state_t                  w_next;
  logic signed [I_BW-1:0]  r_scores [NUM_CLASSES];
  logic [CLS_W-1:0]        r_idx;
  logic [CLS_W-1:0]        r_best_idx;
  logic signed [I_BW-1:0]  r_best_score;
  logic                    r_last_in;

  logic [CLS_W-1:0]        r_class;
  logic signed [I_BW-1:0]  r_score;
  logic                    r_wake;
  logic                    r_valid;
  logic                    r_last;

  logic                    w_accept;
  logic                    w_scan_done;
  logic                    w_out_done;
  logic                    w_in_scan;
  logic signed [I_BW-1:0]  w_cur;
  logic                    w_win;
  logic [CLS_W-1:0]        w_fin_idx;
  logic signed [I_BW-1:0]  w_fin_score;
  logic                    w_detect;
  logic                    w_fire;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (valid_i) w_next = S_SCAN;
      S_SCAN:  if (r_idx == c_LAST_IDX) w_next = S_OUT;
      S_OUT:   if (ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ready_o is gated by reset so upstream never sees a handshake while held in reset.
  always_comb begin
    ready_o     = 1'b0;
    w_accept    = 1'b0;
    w_in_scan   = 1'b0;
    w_scan_done = 1'b0;
    w_out_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready_o  = rst_n_i;
        w_accept = valid_i;
      end
      S_SCAN: begin
        w_in_scan   = 1'b1;
        w_scan_done = (r_idx == c_LAST_IDX);
      end
      S_OUT:   w_out_done = ready_i;
      default: ;
    endcase
  end

  // Strict greater-than keeps the earliest index on ties.
  assign w_cur       = r_scores[r_idx];
  assign w_win       = (w_cur > r_best_score);
  assign w_fin_idx   = w_win ? r_idx : r_best_idx;
  assign w_fin_score = w_win ? w_cur : r_best_score;
  assign w_detect    = (w_fin_idx == c_WAKE_IDX) && (w_fin_score >= c_THRESH);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_CLASSES; i++) r_scores[i] <= '0;
      r_idx        <= '0;
      r_best_idx   <= '0;
      r_best_score <= '0;
      r_last_in    <= 1'b0;
    end else if (w_accept) begin
      for (int i = 0; i < NUM_CLASSES; i++) r_scores[i] <= data_i[i*I_BW +: I_BW];
      r_idx        <= CLS_W'(1);
      r_best_idx   <= '0;
      r_best_score <= data_i[I_BW-1:0];
      r_last_in    <= last_i;
    end else if (w_in_scan) begin
      r_idx        <= r_idx + CLS_W'(1);
      r_best_idx   <= w_fin_idx;
      r_best_score <= w_fin_score;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_class <= '0;
      r_score <= '0;
      r_wake  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_scan_done) begin
      r_class <= w_fin_idx;
      r_score <= w_fin_score;
      r_wake  <= w_fire;
      r_valid <= 1'b1;
      r_last  <= r_last_in;
    end else if (w_out_done) begin
      r_valid <= 1'b0;
      r_wake  <= 1'b0;
    end
  end

  wake_counter #(
    .WAKE_COUNT (WAKE_COUNT)
  ) u_wake_counter (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .frame_i  (w_scan_done),
    .detect_i (w_detect),
    .fire_o   (w_fire)
  );

  assign class_o = r_class;
  assign score_o = r_score;
  assign wake_o  = r_wake;
  assign valid_o = r_valid;
  assign last_o  = r_last;

endmodule

`default_nettype wire

// File: tb/tb_wake_decide.sv
// ============================================================================
// Module : tb_wake_decide
// Brief  : Self-checking bench for wake_decide: vector table, corner sequences, random.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wake_decide;

  logic        clk;
  logic        rst_n_i;
  logic [71:0] data_i;
  logic        valid_i;
  logic        last_i;
  logic        ready_o;
  logic [1:0]  class_o;
  logic [23:0] score_o;
  logic        wake_o;
  logic        valid_o;
  logic        last_o;
  logic        ready_i;

  int n_tests = 0;
  int n_fail  = 0;
  int m_cnt   = 0;

  wake_decide #(
    .I_BW        (24),
    .NUM_CLASSES (3),
    .WAKE_CLASS  (1),
    .THRESH      (100),
    .WAKE_COUNT  (2)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .last_i  (last_i),
    .ready_o (ready_o),
    .class_o (class_o),
    .score_o (score_o),
    .wake_o  (wake_o),
    .valid_o (valid_o),
    .last_o  (last_o),
    .ready_i (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int  s0, s1, s2;
    int  ecls;
    int  escore;
    bit  ewake;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string tag, input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s.%s got %0d expected %0d", tag, nm, act, exp);
    end
  endtask

  // Reference: argmax with earliest-index tie break, then a run-length count of detections.
  task automatic model(input int s0, input int s1, input int s2,
                       output int cls, output int sc, output bit wk);
    int s [3];
    s[0] = s0; s[1] = s1; s[2] = s2;
    cls = 0; sc = s[0];
    for (int i = 1; i < 3; i++) if (s[i] > sc) begin cls = i; sc = s[i]; end
    wk = 1'b0;
    if (cls == 1 && sc >= 100) begin
      m_cnt++;
      if (m_cnt == 2) begin wk = 1'b1; m_cnt = 0; end
    end else begin
      m_cnt = 0;
    end
  endtask

  task automatic do_frame(input int s0, input int s1, input int s2, input bit lst,
                          input int hold, input int ecls, input int escore,
                          input bit ewake, input string tag);
    int w, lat;
    logic [1:0]  c;
    logic [23:0] sc;
    logic        wk, ls;
    w = 0;
    while (!ready_o && w < 20) begin @(posedge clk); @(negedge clk); w++; end
    chk(tag, "ready_in", ready_o, 1);
    data_i  = {24'(s2), 24'(s1), 24'(s0)};
    last_i  = lst;
    valid_i = 1'b1;
    ready_i = (hold == 0);
    @(posedge clk); @(negedge clk);
    valid_i = 1'b0;
    last_i  = 1'b0;
    lat = 0;
    while (!valid_o && lat < 10) begin @(posedge clk); @(negedge clk); lat++; end
    chk(tag, "latency", lat, 2);
    chk(tag, "class", class_o, ecls);
    chk(tag, "score", longint'($signed(score_o)), escore);
    chk(tag, "wake", wake_o, ewake);
    chk(tag, "last", last_o, lst);
    c = class_o; sc = score_o; wk = wake_o; ls = last_o;
    for (int k = 0; k < hold; k++) begin
      if (k == 1) begin
        data_i  = {24'sd500, 24'sd0, 24'sd0};
        valid_i = 1'b1;
      end
      @(posedge clk); @(negedge clk);
      valid_i = 1'b0;
      chk(tag, "hold_stable",
          (valid_o && !ready_o && class_o == c && score_o == sc && wake_o == wk && last_o == ls), 1);
    end
    ready_i = 1'b1;
    @(posedge clk); @(negedge clk);
    chk(tag, "post_valid", valid_o, 0);
    chk(tag, "post_wake", wake_o, 0);
    chk(tag, "post_ready", ready_o, 1);
  endtask

  task automatic set_vec(input int i, input int a, input int b, input int cc,
                         input int cls, input int sc, input bit wk);
    tbl[i].s0 = a; tbl[i].s1 = b; tbl[i].s2 = cc;
    tbl[i].ecls = cls; tbl[i].escore = sc; tbl[i].ewake = wk;
  endtask

  task automatic check_zero(input string tag);
    chk(tag, "valid", valid_o, 0);
    chk(tag, "wake", wake_o, 0);
    chk(tag, "class", class_o, 0);
    chk(tag, "score", score_o, 0);
    chk(tag, "last", last_o, 0);
    chk(tag, "ready", ready_o, 0);
  endtask

  initial begin
    int rc, rs, hits;
    bit rw;
    rst_n_i = 1'b0;
    data_i  = '0;
    valid_i = 1'b0;
    last_i  = 1'b0;
    ready_i = 1'b1;

    set_vec(0,  5, -20, 7,    2, 7, 0);
    set_vec(1,  -50, -50, -60, 0, -50, 0);
    set_vec(2,  0, 150, 10,   1, 150, 0);
    set_vec(3,  0, 150, 10,   1, 150, 1);
    set_vec(4,  0, 150, 10,   1, 150, 0);
    set_vec(5,  0, 99, 0,     1, 99, 0);
    set_vec(6,  0, 150, 0,    1, 150, 0);
    set_vec(7,  0, 99, 0,     1, 99, 0);
    set_vec(8,  0, 150, 0,    1, 150, 0);
    set_vec(9,  0, 100, 100,  1, 100, 1);
    set_vec(10, -8388608, -8388608, -8388608, 0, -8388608, 0);
    set_vec(11, 8388607, 8388607, 0, 0, 8388607, 0);
    set_vec(12, 3, 3, 9,      2, 9, 0);

    #3;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n_i = 1'b1;
    @(negedge clk);
    chk("reset", "ready_after", ready_o, 1);

    for (int i = 0; i < 13; i++)
      do_frame(tbl[i].s0, tbl[i].s1, tbl[i].s2, bit'(i % 2), i % 3,
               tbl[i].ecls, tbl[i].escore, tbl[i].ewake, $sformatf("vec%0d", i));

    // Long backpressure with a dropped pulse; the next frame must see count=1 from the first.
    do_frame(0, 150, 0, 1'b1, 5, 1, 150, 0, "bp_a");
    do_frame(0, 150, 0, 1'b0, 0, 1, 150, 1, "bp_b");

    // Reset mid-SCAN after one detecting frame: history must be cleared.
    do_frame(0, 150, 0, 1'b1, 0, 1, 150, 0, "rst_pre");
    data_i  = {24'sd0, 24'sd150, 24'sd0};
    last_i  = 1'b1;
    valid_i = 1'b1;
    @(posedge clk);
    #3;
    rst_n_i = 1'b0;
    valid_i = 1'b0;
    #1;
    check_zero("rst_mid");
    @(negedge clk);
    rst_n_i = 1'b1;
    hits = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      if (valid_o) hits++;
    end
    chk("rst_mid", "no_output", hits, 0);
    do_frame(0, 150, 0, 1'b0, 0, 1, 150, 0, "rst_post1");
    do_frame(0, 150, 0, 1'b0, 0, 1, 150, 1, "rst_post2");

    // Randomized frames against the reference model, starting from a clean reset.
    rst_n_i = 1'b0;
    @(negedge clk);
    rst_n_i = 1'b1;
    m_cnt = 0;
    for (int n = 0; n < 150; n++) begin
      int a, b, cc;
      a  = int'($urandom_range(0, 300)) - 150;
      b  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(90, 200))
                                       : int'($urandom_range(0, 300)) - 150;
      cc = int'($urandom_range(0, 300)) - 150;
      case ($urandom_range(0, 5))
        0: a  = b;
        1: cc = b;
        2: cc = a;
        default: ;
      endcase
      model(a, b, cc, rc, rs, rw);
      do_frame(a, b, cc, bit'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
               rc, rs, rw, $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
